// File: rtl/room_trace_decoder.sv
// Receive-side decoder for the 8-room walker: recovers the move bit behind each
// observed room transition and flags transitions the walker table cannot produce.
module room_trace_decoder #(
  parameter int CNT_W  = 16,
  parameter bit RESYNC = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             room_valid,
  input  logic [2:0]       room,
  output logic             move_valid,
  output logic             move_out,
  output logic             err,
  output logic             err_sticky,
  output logic             halted,
  output logic [7:0]       move_hist,
  output logic [CNT_W-1:0] move_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       prev_q, prev_d;
  logic             moveValid_q, moveValid_d;
  logic             moveOut_q, moveOut_d;
  logic             err_q, err_d;
  logic             errSticky_q, errSticky_d;
  logic [7:0]       hist_q, hist_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0] succ1, succ0;

  // Inverse walker table: the two rooms reachable from prev, for move=1 and move=0.
  always_comb begin
    succ1 = 3'd0;
    succ0 = 3'd0;
    case (prev_q)
      3'd0: begin succ1 = 3'd1; succ0 = 3'd0; end
      3'd1: begin succ1 = 3'd4; succ0 = 3'd3; end
      3'd2: begin succ1 = 3'd4; succ0 = 3'd3; end
      3'd3: begin succ1 = 3'd0; succ0 = 3'd3; end
      3'd4: begin succ1 = 3'd5; succ0 = 3'd7; end
      3'd5: begin succ1 = 3'd6; succ0 = 3'd3; end
      3'd6: begin succ1 = 3'd6; succ0 = 3'd7; end
      3'd7: begin succ1 = 3'd5; succ0 = 3'd1; end
      default: begin succ1 = 3'd0; succ0 = 3'd0; end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    moveValid_d = 1'b0;
    moveOut_d   = 1'b0;
    err_d       = 1'b0;
    hist_d      = hist_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (room_valid) begin
          if (room == 3'd0) begin
            prev_d  = 3'd0;
            state_d = TRACK;
          end else begin
            err_d = 1'b1;
            if (RESYNC) begin
              prev_d  = room;
              state_d = TRACK;
            end else begin
              state_d = HALT;
            end
          end
        end
      end
      TRACK: begin
        if (room_valid) begin
          if (room == succ1 || room == succ0) begin
            moveValid_d = 1'b1;
            moveOut_d   = (room == succ1);
            prev_d      = room;
            hist_d      = {hist_q[6:0], (room == succ1)};
            // Counter saturates at all-ones while pulses continue.
            if (cnt_q != {CNT_W{1'b1}}) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            err_d = 1'b1;
            if (RESYNC) begin
              prev_d = room;
            end else begin
              state_d = HALT;
            end
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    errSticky_d = errSticky_q | err_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_q      <= 3'd0;
      moveValid_q <= 1'b0;
      moveOut_q   <= 1'b0;
      err_q       <= 1'b0;
      errSticky_q <= 1'b0;
      hist_q      <= 8'd0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      moveValid_q <= moveValid_d;
      moveOut_q   <= moveOut_d;
      err_q       <= err_d;
      errSticky_q <= errSticky_d;
      hist_q      <= hist_d;
      cnt_q       <= cnt_d;
    end
  end

  assign move_valid = moveValid_q;
  assign move_out   = moveOut_q;
  assign err        = err_q;
  assign err_sticky = errSticky_q;
  assign halted     = (state_q == HALT);
  assign move_hist  = hist_q;
  assign move_cnt   = cnt_q;

endmodule

// File: tb/tb_room_trace_decoder.sv
// Directed bench for room_trace_decoder: three instances cover RESYNC=1, RESYNC=0
// and a narrow saturating counter, all driven from one shared stimulus.
module tb_room_trace_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic roomValid = 1'b0;
  logic [2:0] room = 3'd0;

  logic aMv, aMo, aErr, aSticky, aHalted;
  logic [7:0] aHist;
  logic [15:0] aCnt;
  logic hMv, hMo, hErr, hSticky, hHalted;
  logic [7:0] hHist;
  logic [15:0] hCnt;
  logic sMv, sMo, sErr, sSticky, sHalted;
  logic [7:0] sHist;
  logic [3:0] sCnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  room_trace_decoder #(.CNT_W(16), .RESYNC(1'b1)) dutA (
    .clk(clk), .rst(rst), .room_valid(roomValid), .room(room),
    .move_valid(aMv), .move_out(aMo), .err(aErr), .err_sticky(aSticky),
    .halted(aHalted), .move_hist(aHist), .move_cnt(aCnt));

  room_trace_decoder #(.CNT_W(16), .RESYNC(1'b0)) dutH (
    .clk(clk), .rst(rst), .room_valid(roomValid), .room(room),
    .move_valid(hMv), .move_out(hMo), .err(hErr), .err_sticky(hSticky),
    .halted(hHalted), .move_hist(hHist), .move_cnt(hCnt));

  room_trace_decoder #(.CNT_W(4), .RESYNC(1'b1)) dutS (
    .clk(clk), .rst(rst), .room_valid(roomValid), .room(room),
    .move_valid(sMv), .move_out(sMo), .err(sErr), .err_sticky(sSticky),
    .halted(sHalted), .move_hist(sHist), .move_cnt(sCnt));

  typedef struct {
    logic       valid;
    logic [2:0] room;
    logic       expMv;
    logic       expMo;
    logic       expErr;
  } vec_t;

  vec_t trace[11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of input, then sample just after the capturing edge.
  task automatic applyStimulus(input logic v, input logic [2:0] r);
    @(negedge clk);
    roomValid = v;
    room      = r;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst       = 1'b1;
    roomValid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkAllZeroA(input string tag);
    checkOutput({tag, " mv"}, 32'(aMv), 32'd0);
    checkOutput({tag, " mo"}, 32'(aMo), 32'd0);
    checkOutput({tag, " err"}, 32'(aErr), 32'd0);
    checkOutput({tag, " sticky"}, 32'(aSticky), 32'd0);
    checkOutput({tag, " halted"}, 32'(aHalted), 32'd0);
    checkOutput({tag, " hist"}, 32'(aHist), 32'd0);
    checkOutput({tag, " cnt"}, 32'(aCnt), 32'd0);
  endtask

  task automatic runVector(input vec_t v, input string tag);
    applyStimulus(v.valid, v.room);
    checkOutput({tag, " mv"}, 32'(aMv), 32'(v.expMv));
    if (v.expMv) checkOutput({tag, " mo"}, 32'(aMo), 32'(v.expMo));
    checkOutput({tag, " err"}, 32'(aErr), 32'(v.expErr));
  endtask

  initial begin
    trace[0]  = '{1'b1, 3'd0, 1'b0, 1'b0, 1'b0};
    trace[1]  = '{1'b1, 3'd1, 1'b1, 1'b1, 1'b0};
    trace[2]  = '{1'b1, 3'd4, 1'b1, 1'b1, 1'b0};
    trace[3]  = '{1'b1, 3'd5, 1'b1, 1'b1, 1'b0};
    trace[4]  = '{1'b1, 3'd6, 1'b1, 1'b1, 1'b0};
    trace[5]  = '{1'b1, 3'd6, 1'b1, 1'b1, 1'b0};
    trace[6]  = '{1'b1, 3'd7, 1'b1, 1'b0, 1'b0};
    trace[7]  = '{1'b1, 3'd1, 1'b1, 1'b0, 1'b0};
    trace[8]  = '{1'b1, 3'd3, 1'b1, 1'b0, 1'b0};
    trace[9]  = '{1'b1, 3'd3, 1'b1, 1'b0, 1'b0};
    trace[10] = '{1'b1, 3'd0, 1'b1, 1'b1, 1'b0};

    // T1: back-to-back trace
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkAllZeroA("reset");
    checkOutput("reset halted H", 32'(hHalted), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 11; i++) runVector(trace[i], $sformatf("T1[%0d]", i));
    applyStimulus(1'b0, 3'd0);
    checkOutput("T1 idle mv", 32'(aMv), 32'd0);
    checkOutput("T1 cnt", 32'(aCnt), 32'd10);
    checkOutput("T1 hist", 32'(aHist), 32'hE1);
    checkOutput("T1 sticky", 32'(aSticky), 32'd0);
    checkOutput("T1 cnt H", 32'(hCnt), 32'd10);
    checkOutput("T1 cnt S", 32'(sCnt), 32'd10);

    // T2: same trace with gaps of 1-3 idle cycles
    doReset();
    for (int i = 0; i < 11; i++) begin
      runVector(trace[i], $sformatf("T2[%0d]", i));
      for (int g = 0; g < int'($urandom_range(3, 1)); g++) begin
        applyStimulus(1'b0, 3'($urandom_range(7, 0)));
        checkOutput($sformatf("T2 gap%0d mv", i), 32'(aMv), 32'd0);
        checkOutput($sformatf("T2 gap%0d err", i), 32'(aErr), 32'd0);
      end
    end
    checkOutput("T2 cnt", 32'(aCnt), 32'd10);
    checkOutput("T2 hist", 32'(aHist), 32'hE1);

    // T3: bad first sample with resync
    doReset();
    applyStimulus(1'b1, 3'd5);
    checkOutput("T3 s5 err", 32'(aErr), 32'd1);
    checkOutput("T3 s5 sticky", 32'(aSticky), 32'd1);
    checkOutput("T3 s5 mv", 32'(aMv), 32'd0);
    checkOutput("T3 H halted", 32'(hHalted), 32'd1);
    applyStimulus(1'b1, 3'd6);
    checkOutput("T3 s6 mv", 32'(aMv), 32'd1);
    checkOutput("T3 s6 mo", 32'(aMo), 32'd1);
    checkOutput("T3 s6 err", 32'(aErr), 32'd0);
    applyStimulus(1'b1, 3'd3);
    checkOutput("T3 s3 err", 32'(aErr), 32'd1);
    checkOutput("T3 s3 mv", 32'(aMv), 32'd0);
    applyStimulus(1'b1, 3'd0);
    checkOutput("T3 s0 mv", 32'(aMv), 32'd1);
    checkOutput("T3 s0 mo", 32'(aMo), 32'd1);
    checkOutput("T3 cnt", 32'(aCnt), 32'd2);
    checkOutput("T3 hist", 32'(aHist), 32'h03);
    checkOutput("T3 halted A", 32'(aHalted), 32'd0);

    // T4: halt on illegal transition without resync
    doReset();
    applyStimulus(1'b1, 3'd0);
    checkOutput("T4 s0 err", 32'(hErr), 32'd0);
    applyStimulus(1'b1, 3'd1);
    checkOutput("T4 s1 mv", 32'(hMv), 32'd1);
    checkOutput("T4 s1 mo", 32'(hMo), 32'd1);
    applyStimulus(1'b1, 3'd2);
    checkOutput("T4 s2 err", 32'(hErr), 32'd1);
    checkOutput("T4 s2 mv", 32'(hMv), 32'd0);
    checkOutput("T4 halted", 32'(hHalted), 32'd1);
    applyStimulus(1'b1, 3'd4);
    checkOutput("T4 s4 mv", 32'(hMv), 32'd0);
    checkOutput("T4 s4 err", 32'(hErr), 32'd0);
    applyStimulus(1'b1, 3'd5);
    checkOutput("T4 s5 mv", 32'(hMv), 32'd0);
    checkOutput("T4 cnt", 32'(hCnt), 32'd1);
    checkOutput("T4 sticky", 32'(hSticky), 32'd1);
    checkOutput("T4 halted2", 32'(hHalted), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    roomValid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("T4 rst halted", 32'(hHalted), 32'd0);
    checkOutput("T4 rst sticky", 32'(hSticky), 32'd0);
    checkOutput("T4 rst cnt", 32'(hCnt), 32'd0);
    checkOutput("T4 rst hist", 32'(hHist), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 3'd0);
    checkOutput("T4 idle s0 err", 32'(hErr), 32'd0);
    applyStimulus(1'b1, 3'd1);
    checkOutput("T4 retrack mv", 32'(hMv), 32'd1);

    // T5: saturation on the 4-bit counter instance
    doReset();
    applyStimulus(1'b1, 3'd0);
    checkOutput("T5 first mv", 32'(sMv), 32'd0);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b1, 3'd0);
      checkOutput($sformatf("T5[%0d] mv", i), 32'(sMv), 32'd1);
      checkOutput($sformatf("T5[%0d] mo", i), 32'(sMo), 32'd0);
      checkOutput($sformatf("T5[%0d] cnt", i), 32'(sCnt), 32'((i > 15) ? 15 : i));
    end
    checkOutput("T5 err", 32'(sSticky), 32'd0);

    // T6: reset coinciding with a valid sample
    doReset();
    applyStimulus(1'b1, 3'd0);
    applyStimulus(1'b1, 3'd1);
    checkOutput("T6 pre mv", 32'(aMv), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    roomValid = 1'b1;
    room = 3'd4;
    @(posedge clk);
    #1;
    checkAllZeroA("T6 rst");
    @(negedge clk);
    rst = 1'b0;
    roomValid = 1'b0;
    applyStimulus(1'b1, 3'd0);
    checkOutput("T6 s0 err", 32'(aErr), 32'd0);
    checkOutput("T6 s0 mv", 32'(aMv), 32'd0);
    applyStimulus(1'b1, 3'd1);
    checkOutput("T6 s1 mv", 32'(aMv), 32'd1);
    checkOutput("T6 cnt", 32'(aCnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
